// File: rtl/bus_arbiter_pkg.sv
// Shared MESI bus types (package mesi_types): bus commands, arbiter states
// and the fixed upper bound on cache count.
package mesi_types;

  typedef enum logic [1:0] {
    No_OP   = 2'd0,
    BusRd   = 2'd1,
    BusRdX  = 2'd2,
    BusUpgr = 2'd3
  } bus_request;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    SNOOP = 2'd2
  } arb_state_t;

  // Internal request vectors are always this wide so 2-bit indices fit exactly.
  localparam int unsigned MAX_CACHES = 4;

endpackage

// File: rtl/bus_arbiter_if.sv
// Snooping-bus arbitration interface: per-cache requests in, grant and
// broadcast out. master = cache side, slave = arbiter side.
interface bus_arbiter_if
  import mesi_types::*;
#(
  parameter int unsigned NUM_CACHES = 2
);

  bus_request            req_cmd  [NUM_CACHES];
  logic [7:0]            req_addr [NUM_CACHES];
  logic [NUM_CACHES-1:0] grant;
  bus_request            cmd_out;
  logic [7:0]            addr_out;
  logic [1:0]            owner;
  logic                  busy;

  modport master (
    output req_cmd, req_addr,
    input  grant, cmd_out, addr_out, owner, busy
  );

  modport slave (
    input  req_cmd, req_addr,
    output grant, cmd_out, addr_out, owner, busy
  );

endinterface

// File: rtl/bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit after last_winner,
// wrapping modulo NUM_CACHES.
module rr_picker
  import mesi_types::*;
#(
  parameter int unsigned NUM_CACHES = 2
) (
  input  logic [MAX_CACHES-1:0] req,
  input  logic [1:0]            last_winner,
  output logic [1:0]            winner,
  output logic                  any_valid
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_CACHES - 1);

  logic [1:0] cand;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    cand      = last_winner;
    for (int unsigned off = 0; off < NUM_CACHES; off++) begin
      cand = (cand == LAST_IDX) ? 2'd0 : cand + 2'd1;
      if (!any_valid && req[cand]) begin
        any_valid = 1'b1;
        winner    = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Snooping-bus arbiter: IDLE -> GRANT (1 cycle) -> SNOOP (SNOOP_CYCLES) -> IDLE.
// Define MESI_UPGR_PRIORITY_EN to let BusUpgr requests beat BusRd/BusRdX.
module bus_arbiter
  import mesi_types::*;
#(
  parameter int unsigned NUM_CACHES   = 2,
  parameter int unsigned SNOOP_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  bus
);

  localparam logic [3:0]            SNOOP_LOAD  = 4'(SNOOP_CYCLES);
  localparam logic [1:0]            LAST_RESET  = 2'(NUM_CACHES - 1);
  localparam logic [NUM_CACHES-1:0] GRANT_ONE   = NUM_CACHES'(1);

  arb_state_t            state;
  logic [3:0]            snoop_cnt;
  logic [1:0]            last_winner;
  logic [1:0]            winner;
  logic                  any_valid;

  logic [MAX_CACHES-1:0] req_valid;
  bus_request            cmd_pad  [MAX_CACHES];
  logic [7:0]            addr_pad [MAX_CACHES];

  // Pad to MAX_CACHES so the winner index selects without width adaptation.
  for (genvar g = 0; g < MAX_CACHES; g++) begin : g_pad
    if (g < int'(NUM_CACHES)) begin : g_live
      assign cmd_pad[g]  = bus.req_cmd[g];
      assign addr_pad[g] = bus.req_addr[g];
    end else begin : g_tie
      assign cmd_pad[g]  = No_OP;
      assign addr_pad[g] = '0;
    end
    assign req_valid[g] = (cmd_pad[g] != No_OP);
  end

`ifdef MESI_UPGR_PRIORITY_EN
  logic [MAX_CACHES-1:0] req_upgr;
  logic [1:0]            upgr_winner;
  logic [1:0]            all_winner;
  logic                  upgr_valid;

  for (genvar g = 0; g < MAX_CACHES; g++) begin : g_upgr
    assign req_upgr[g] = (cmd_pad[g] == BusUpgr);
  end

  rr_picker #(.NUM_CACHES(NUM_CACHES)) u_pick_upgr (
    .req         (req_upgr),
    .last_winner (last_winner),
    .winner      (upgr_winner),
    .any_valid   (upgr_valid)
  );

  rr_picker #(.NUM_CACHES(NUM_CACHES)) u_pick_all (
    .req         (req_valid),
    .last_winner (last_winner),
    .winner      (all_winner),
    .any_valid   (any_valid)
  );

  // Any BusUpgr is also a valid request, so any_valid covers both pickers.
  assign winner = upgr_valid ? upgr_winner : all_winner;
`else
  rr_picker #(.NUM_CACHES(NUM_CACHES)) u_pick (
    .req         (req_valid),
    .last_winner (last_winner),
    .winner      (winner),
    .any_valid   (any_valid)
  );
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      snoop_cnt    <= '0;
      last_winner  <= LAST_RESET;
      bus.grant    <= '0;
      bus.cmd_out  <= No_OP;
      bus.addr_out <= '0;
      bus.owner    <= '0;
      bus.busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state        <= GRANT;
            bus.grant    <= GRANT_ONE << winner;
            bus.cmd_out  <= cmd_pad[winner];
            bus.addr_out <= addr_pad[winner];
            bus.owner    <= winner;
            bus.busy     <= 1'b1;
          end
        end
        GRANT: begin
          state       <= SNOOP;
          snoop_cnt   <= SNOOP_LOAD;
          bus.grant   <= '0;
          bus.cmd_out <= No_OP;
        end
        SNOOP: begin
          if (snoop_cnt == 4'd1) begin
            state       <= IDLE;
            snoop_cnt   <= '0;
            bus.busy    <= 1'b0;
            last_winner <= bus.owner;
          end else begin
            snoop_cnt <= snoop_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (SNOOP_CYCLES=2 and =4 instances).
module tb_bus_arbiter;
  import mesi_types::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_CACHES(2)) bif ();
  bus_arbiter_if #(.NUM_CACHES(2)) bif4 ();

  bus_arbiter #(.NUM_CACHES(2), .SNOOP_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  bus_arbiter #(.NUM_CACHES(2), .SNOOP_CYCLES(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bif4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drive(input int c, input bus_request cmd, input logic [7:0] a);
    bif.req_cmd[c]  = cmd;
    bif.req_addr[c] = a;
  endtask

  task automatic test_reset();
    step();
    total++; if (bif.grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b exp=00", bif.grant); end
    total++; if (bif.cmd_out !== No_OP) begin bad++; $display("FAIL reset_cmd got=%0d exp=0", bif.cmd_out); end
    total++; if (bif.addr_out !== 8'h00) begin bad++; $display("FAIL reset_addr got=%h exp=00", bif.addr_out); end
    total++; if (bif.owner !== 2'd0) begin bad++; $display("FAIL reset_owner got=%0d exp=0", bif.owner); end
    total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bif.busy); end
  endtask

  task automatic test_single();
    int busy_cycles;
    do_reset();
    drive(0, BusRd, 8'h10);
    step();
    total++; if (bif.grant !== 2'b01) begin bad++; $display("FAIL single_grant got=%b exp=01", bif.grant); end
    total++; if (bif.cmd_out !== BusRd) begin bad++; $display("FAIL single_cmd got=%0d exp=1", bif.cmd_out); end
    total++; if (bif.addr_out !== 8'h10) begin bad++; $display("FAIL single_addr got=%h exp=10", bif.addr_out); end
    total++; if (bif.owner !== 2'd0) begin bad++; $display("FAIL single_owner got=%0d exp=0", bif.owner); end
    drive(0, No_OP, 8'h00);
    busy_cycles = (bif.busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bif.busy === 1'b1) busy_cycles++;
      if (i == 0) begin
        total++; if (bif.grant !== 2'b00 || bif.cmd_out !== No_OP) begin
          bad++; $display("FAIL single_snoop_out got=%b/%0d exp=00/0", bif.grant, bif.cmd_out);
        end
        total++; if (bif.addr_out !== 8'h10) begin bad++; $display("FAIL single_snoop_addr got=%h exp=10", bif.addr_out); end
      end
    end
    total++; if (busy_cycles != 3) begin bad++; $display("FAIL single_busy_len got=%0d exp=3", busy_cycles); end
    total++; if (bif.addr_out !== 8'h10 || bif.owner !== 2'd0) begin
      bad++; $display("FAIL single_idle_hold got=%h/%0d exp=10/0", bif.addr_out, bif.owner);
    end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_grant [3];
    logic [7:0] exp_addr  [3];
    bus_request exp_cmd   [3];
    exp_grant = '{2'b01, 2'b10, 2'b01};
    exp_addr  = '{8'h20, 8'h30, 8'h20};
    exp_cmd   = '{BusRd, BusRdX, BusRd};
    do_reset();
    drive(0, BusRd, 8'h20);
    drive(1, BusRdX, 8'h30);
    for (int t = 0; t < 3; t++) begin
      step();
      total++; if (bif.grant !== exp_grant[t]) begin bad++; $display("FAIL alt_grant%0d got=%b exp=%b", t, bif.grant, exp_grant[t]); end
      total++; if (bif.cmd_out !== exp_cmd[t]) begin bad++; $display("FAIL alt_cmd%0d got=%0d exp=%0d", t, bif.cmd_out, exp_cmd[t]); end
      total++; if (bif.addr_out !== exp_addr[t]) begin bad++; $display("FAIL alt_addr%0d got=%h exp=%h", t, bif.addr_out, exp_addr[t]); end
      step();
      step();
      if (t == 2) begin
        drive(0, No_OP, 8'h00);
        drive(1, No_OP, 8'h00);
      end
      step();
      total++; if (bif.busy !== 1'b0 || bif.grant !== 2'b00) begin
        bad++; $display("FAIL alt_idle%0d got=%b/%b exp=0/00", t, bif.busy, bif.grant);
      end
    end
  endtask

  task automatic test_snoop4();
    int busy_n = 0;
    int cmd_n  = 0;
    do_reset();
    bif4.req_cmd[1]  = BusRdX;
    bif4.req_addr[1] = 8'h44;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) begin
        bif4.req_cmd[1] = No_OP;
        total++; if (bif4.grant !== 2'b10 || bif4.addr_out !== 8'h44) begin
          bad++; $display("FAIL snoop4_grant got=%b/%h exp=10/44", bif4.grant, bif4.addr_out);
        end
        total++; if (bif4.cmd_out !== BusRdX) begin bad++; $display("FAIL snoop4_first_cmd got=%0d exp=2", bif4.cmd_out); end
      end
      if (bif4.busy === 1'b1) busy_n++;
      if (bif4.cmd_out === BusRdX) cmd_n++;
    end
    total++; if (busy_n != 5) begin bad++; $display("FAIL snoop4_busy_len got=%0d exp=5", busy_n); end
    total++; if (cmd_n != 1) begin bad++; $display("FAIL snoop4_cmd_len got=%0d exp=1", cmd_n); end
  endtask

  task automatic test_priority();
    logic [1:0] eg;
    logic [7:0] ea;
`ifdef MESI_UPGR_PRIORITY_EN
    eg = 2'b10; ea = 8'h02;
`else
    eg = 2'b01; ea = 8'h01;
`endif
    do_reset();
    drive(0, BusRd, 8'h01);
    drive(1, BusUpgr, 8'h02);
    step();
    total++; if (bif.grant !== eg) begin bad++; $display("FAIL prio_grant got=%b exp=%b", bif.grant, eg); end
    total++; if (bif.addr_out !== ea) begin bad++; $display("FAIL prio_addr got=%h exp=%h", bif.addr_out, ea); end
    drive(0, No_OP, 8'h00);
    drive(1, No_OP, 8'h00);
    step(); step(); step();
  endtask

  task automatic test_reset_abort();
    do_reset();
    drive(1, BusRdX, 8'h77);
    step();
    total++; if (bif.grant !== 2'b10) begin bad++; $display("FAIL abort_pre_grant got=%b exp=10", bif.grant); end
    drive(1, No_OP, 8'h00);
    drive(0, BusRd, 8'h10);
    step();
    rst = 1'b1;
    #1;
    total++; if (bif.busy !== 1'b0 || bif.grant !== 2'b00) begin
      bad++; $display("FAIL abort_async got=%b/%b exp=0/00", bif.busy, bif.grant);
    end
    total++; if (bif.addr_out !== 8'h00 || bif.owner !== 2'd0 || bif.cmd_out !== No_OP) begin
      bad++; $display("FAIL abort_vals got=%h/%0d/%0d exp=00/0/0", bif.addr_out, bif.owner, bif.cmd_out);
    end
    step();
    total++; if (bif.grant !== 2'b00 || bif.busy !== 1'b0) begin
      bad++; $display("FAIL abort_held got=%b/%b exp=00/0", bif.grant, bif.busy);
    end
    rst = 1'b0;
    step();
    total++; if (bif.grant !== 2'b01 || bif.addr_out !== 8'h10) begin
      bad++; $display("FAIL abort_resume got=%b/%h exp=01/10", bif.grant, bif.addr_out);
    end
    drive(0, No_OP, 8'h00);
    step(); step(); step();
  endtask

  task automatic test_addr_hold();
    do_reset();
    drive(0, BusRd, 8'h50);
    step();
    total++; if (bif.addr_out !== 8'h50) begin bad++; $display("FAIL hold_grant_addr got=%h exp=50", bif.addr_out); end
    drive(0, BusRd, 8'h60);
    drive(1, BusRdX, 8'h99);
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (bif.addr_out !== 8'h50) begin bad++; $display("FAIL hold_snoop%0d got=%h exp=50", i, bif.addr_out); end
    end
    drive(0, No_OP, 8'h00);
    drive(1, No_OP, 8'h00);
    step();
    total++; if (bif.addr_out !== 8'h50 || bif.busy !== 1'b0) begin
      bad++; $display("FAIL hold_idle got=%h/%b exp=50/0", bif.addr_out, bif.busy);
    end
    step();
    total++; if (bif.grant !== 2'b00 || bif.busy !== 1'b0) begin
      bad++; $display("FAIL withdrawn_grant got=%b/%b exp=00/0", bif.grant, bif.busy);
    end
  endtask

  initial begin
    for (int c = 0; c < 2; c++) begin
      bif.req_cmd[c]   = No_OP;
      bif.req_addr[c]  = 8'h00;
      bif4.req_cmd[c]  = No_OP;
      bif4.req_addr[c] = 8'h00;
    end
    test_reset();
    test_single();
    test_alternate();
    test_snoop4();
    test_priority();
    test_reset_abort();
    test_addr_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
